// File: rtl/minionsii_nios2_debug_pkg.sv
// Shared types and jdo field map for the Nios II OCI debug monitor.
package minionsii_nios2_debug_pkg;

    localparam int RAM_ADDR_W_DEF = 8;
    localparam int DATA_W         = 32;
    localparam int BE_W           = DATA_W / 8;

    localparam int JDO_W          = 38;
    localparam int JDO_RD_BIT     = 35;
    localparam int JDO_ADDR_LSB   = 26;
    localparam int JDO_ERRCLR_BIT = 25;
    localparam int JDO_WDATA_LSB  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_JRD    = 3'd1,
        ST_JCAP   = 3'd2,
        ST_AVRD   = 3'd3,
        ST_AVDONE = 3'd4
    } mon_state_e;

    function automatic logic [DATA_W-1:0] jdo_wdata(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_WDATA_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/minionsii_nios2_gen2_0_cpu_ociram_sp_ram.sv
// Single-port monitor RAM, byte-enabled writes, registered read (1-cycle latency).
module minionsii_nios2_gen2_0_cpu_ociram_sp_ram
    import minionsii_nios2_debug_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BE_W-1:0]   i_be,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;

    // No reset: contents must survive a debug-monitor reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        r_q <= r_mem[i_addr];
    end

    assign o_q = r_q;

endmodule

// File: rtl/minionsii_nios2_gen2_0_cpu_debug_monitor.sv
// OCI debug monitor: arbitrates JTAG debug-slave and Avalon CPU access to the monitor RAM.
module minionsii_nios2_gen2_0_cpu_debug_monitor
    import minionsii_nios2_debug_pkg::*;
#(
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [JDO_W-1:0]      jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic                  take_no_action_ocimem_a,
    input  logic [RAM_ADDR_W-1:0] avalon_address,
    input  logic                  avalon_read,
    input  logic                  avalon_write,
    input  logic [DATA_W-1:0]     avalon_writedata,
    input  logic [BE_W-1:0]       avalon_byteenable,
    output logic [DATA_W-1:0]     avalon_readdata,
    output logic                  avalon_waitrequest,
    output logic [DATA_W-1:0]     MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error
);

    mon_state_e            r_state, w_state_nxt;
    logic [RAM_ADDR_W-1:0] r_mon_a;
    logic [DATA_W-1:0]     r_mon_d, r_rdata;
    logic                  r_rd_pending, w_rd_pending_nxt;
    logic                  r_ready, r_error;

    logic                  w_strobe, w_idle, w_waitreq;
    logic                  w_ram_we;
    logic [RAM_ADDR_W-1:0] w_ram_addr;
    logic [BE_W-1:0]       w_ram_be;
    logic [DATA_W-1:0]     w_ram_wdata, w_ram_q;
    logic                  w_unused_jdo;

    assign w_strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_idle       = (r_state == ST_IDLE);
    assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rd_pending_nxt = r_rd_pending;
        case (r_state)
            ST_IDLE: begin
                if (take_action_ocimem_a)
                    w_rd_pending_nxt = jdo[JDO_RD_BIT];
                else if (!take_action_ocimem_b && take_no_action_ocimem_a && r_rd_pending)
                    w_state_nxt = ST_JRD;
                else if (!w_strobe && avalon_read)
                    w_state_nxt = ST_AVRD;
            end
            ST_JRD:    w_state_nxt = ST_JCAP;
            ST_JCAP: begin
                w_state_nxt      = ST_IDLE;
                w_rd_pending_nxt = 1'b0;
            end
            ST_AVRD:   w_state_nxt = ST_AVDONE;
            ST_AVDONE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM port steering and Avalon stall. A read is stalled from acceptance until
    // AVDONE so the master keeps address and read asserted through AVRD.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_be    = '1;
        w_ram_addr  = avalon_address;
        w_ram_wdata = avalon_writedata;
        case (r_state)
            ST_IDLE: begin
                if (take_action_ocimem_b && !take_action_ocimem_a) begin
                    w_ram_we    = 1'b1;
                    w_ram_addr  = r_mon_a;
                    w_ram_wdata = jdo_wdata(jdo);
                end else if (!w_strobe && avalon_write) begin
                    w_ram_we = 1'b1;
                    w_ram_be = avalon_byteenable;
                end
            end
            ST_JRD:  w_ram_addr = r_mon_a;
            default: w_ram_we = 1'b0;
        endcase

        if (r_state == ST_AVDONE) w_waitreq = 1'b0;
        else if (avalon_read)     w_waitreq = 1'b1;
        else if (avalon_write)    w_waitreq = !w_idle || w_strobe;
        else                      w_waitreq = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mon_a      <= '0;
            r_mon_d      <= '0;
            r_rdata      <= '0;
            r_rd_pending <= 1'b0;
            r_ready      <= 1'b1;
            r_error      <= 1'b0;
        end else begin
            r_rd_pending <= w_rd_pending_nxt;
            r_ready      <= (w_state_nxt == ST_IDLE) && !w_rd_pending_nxt;
            if (w_strobe && !w_idle) r_error <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (take_action_ocimem_a) begin
                        r_mon_a <= jdo[JDO_ADDR_LSB +: RAM_ADDR_W];
                        if (jdo[JDO_ERRCLR_BIT]) r_error <= 1'b0;
                    end else if (take_action_ocimem_b) begin
                        r_mon_d <= jdo_wdata(jdo);
                        r_mon_a <= r_mon_a + RAM_ADDR_W'(1);
                    end
                end
                ST_JCAP: begin
                    r_mon_d <= w_ram_q;
                    r_mon_a <= r_mon_a + RAM_ADDR_W'(1);
                end
                ST_AVDONE: r_rdata <= w_ram_q;
                default:   r_rdata <= r_rdata;
            endcase
        end
    end

    minionsii_nios2_gen2_0_cpu_ociram_sp_ram #(
        .ADDR_W (RAM_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we & reset_n),
        .i_addr  (w_ram_addr),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

    assign avalon_readdata    = (r_state == ST_AVDONE) ? w_ram_q : r_rdata;
    assign avalon_waitrequest = w_waitreq;
    assign MonDReg            = r_mon_d;
    assign monitor_ready      = r_ready;
    assign monitor_error      = r_error;

endmodule

// File: tb/tb_minionsii_nios2_gen2_0_cpu_debug_monitor.sv
// Directed vector bench for the OCI debug monitor.
module tb_minionsii_nios2_gen2_0_cpu_debug_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  avalon_address;
    logic        avalon_read, avalon_write;
    logic [31:0] avalon_writedata;
    logic [3:0]  avalon_byteenable;
    logic [31:0] avalon_readdata;
    logic        avalon_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    always #5 clk = ~clk;

    minionsii_nios2_gen2_0_cpu_debug_monitor #(.RAM_ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avalon_address          (avalon_address),
        .avalon_read             (avalon_read),
        .avalon_write            (avalon_write),
        .avalon_writedata        (avalon_writedata),
        .avalon_byteenable       (avalon_byteenable),
        .avalon_readdata         (avalon_readdata),
        .avalon_waitrequest      (avalon_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    typedef struct {
        logic        a, b, na;
        logic [37:0] jdo;
        logic        rd, wr;
        logic [7:0]  adr;
        logic [31:0] wd;
        logic [3:0]  be;
    } stim_t;

    typedef struct {
        string       nm;
        stim_t       s;
        logic        ew;
        logic [31:0] emd;
        logic        erdy, eerr;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic stim_t s_idle();
        stim_t s;
        s = '{a: 1'b0, b: 1'b0, na: 1'b0, jdo: '0, rd: 1'b0, wr: 1'b0, adr: '0, wd: '0, be: '0};
        return s;
    endfunction

    function automatic stim_t s_ja(input logic rd, input logic [7:0] adr, input logic clr);
        stim_t s = s_idle();
        s.a = 1'b1;
        s.jdo[35] = rd;
        s.jdo[33:26] = adr;
        s.jdo[25] = clr;
        return s;
    endfunction

    function automatic stim_t s_jb(input logic [31:0] wd);
        stim_t s = s_idle();
        s.b = 1'b1;
        s.jdo[34:3] = wd;
        return s;
    endfunction

    function automatic stim_t s_na();
        stim_t s = s_idle();
        s.na = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_ar(input logic [7:0] adr);
        stim_t s = s_idle();
        s.rd = 1'b1;
        s.adr = adr;
        return s;
    endfunction

    function automatic stim_t s_aw(input logic [7:0] adr, input logic [31:0] wd, input logic [3:0] be);
        stim_t s = s_idle();
        s.wr = 1'b1;
        s.adr = adr;
        s.wd = wd;
        s.be = be;
        return s;
    endfunction

    function automatic stim_t s_or(input stim_t x, input stim_t y);
        stim_t s;
        s.a = x.a | y.a;    s.b = x.b | y.b;    s.na = x.na | y.na;
        s.jdo = x.jdo | y.jdo;
        s.rd = x.rd | y.rd; s.wr = x.wr | y.wr;
        s.adr = x.adr | y.adr; s.wd = x.wd | y.wd; s.be = x.be | y.be;
        return s;
    endfunction

    function automatic vec_t v(input string nm, input stim_t s, input logic ew, input logic [31:0] emd,
                               input logic erdy, input logic eerr, input logic [31:0] erd);
        vec_t r;
        r.nm = nm; r.s = s; r.ew = ew; r.emd = emd; r.erdy = erdy; r.eerr = eerr; r.erd = erd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        take_action_ocimem_a    = s.a;
        take_action_ocimem_b    = s.b;
        take_no_action_ocimem_a = s.na;
        jdo                     = s.jdo;
        avalon_read             = s.rd;
        avalon_write            = s.wr;
        avalon_address          = s.adr;
        avalon_writedata        = s.wd;
        avalon_byteenable       = s.be;
    endtask

    task automatic chk_regs(input string nm, input logic [31:0] emd, input logic erdy,
                            input logic eerr, input logic [31:0] erd);
        chk({nm, ".MonDReg"},  MonDReg, emd);
        chk({nm, ".ready"},    32'(monitor_ready), 32'(erdy));
        chk({nm, ".error"},    32'(monitor_error), 32'(eerr));
        chk({nm, ".readdata"}, avalon_readdata, erd);
    endtask

    task automatic run(input vec_t x);
        @(negedge clk);
        drive(x.s);
        #1;
        chk({x.nm, ".wait"}, 32'(avalon_waitrequest), 32'(x.ew));
        @(posedge clk);
        #1;
        chk_regs(x.nm, x.emd, x.erdy, x.eerr, x.erd);
    endtask

    initial begin
        // JTAG write/read round trip
        vecs.push_back(v("ja_10",     s_ja(1'b0, 8'h10, 1'b0), 1'b0, 32'h0,        1'b1, 1'b0, 32'h0));
        vecs.push_back(v("jb_dead",   s_jb(32'hDEADBEEF),      1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0));
        vecs.push_back(v("ja_40",     s_ja(1'b0, 8'h40, 1'b0), 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0));
        vecs.push_back(v("jb_cafe",   s_jb(32'hCAFEF00D),      1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0));
        vecs.push_back(v("ja_10_rd",  s_ja(1'b1, 8'h10, 1'b0), 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0));
        vecs.push_back(v("na_N",      s_na(),                  1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0));
        vecs.push_back(v("jrd_N1",    s_idle(),                1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0));
        vecs.push_back(v("jcap_N2",   s_idle(),                1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0));
        vecs.push_back(v("jb_at_11",  s_jb(32'h11111111),      1'b0, 32'h11111111, 1'b1, 1'b0, 32'h0));
        vecs.push_back(v("ar11_c0",   s_ar(8'h11),             1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0));
        vecs.push_back(v("ar11_c1",   s_ar(8'h11),             1'b1, 32'h11111111, 1'b0, 1'b0, 32'h11111111));
        vecs.push_back(v("ar11_c2",   s_ar(8'h11),             1'b0, 32'h11111111, 1'b1, 1'b0, 32'h11111111));
        // Avalon byte-enable write and 2-cycle read
        vecs.push_back(v("aw20_full", s_aw(8'h20, 32'hFFFFFFFF, 4'hF), 1'b0, 32'h11111111, 1'b1, 1'b0, 32'h11111111));
        vecs.push_back(v("aw20_be3",  s_aw(8'h20, 32'h12345678, 4'h3), 1'b0, 32'h11111111, 1'b1, 1'b0, 32'h11111111));
        vecs.push_back(v("ar20_c0",   s_ar(8'h20),             1'b1, 32'h11111111, 1'b0, 1'b0, 32'h11111111));
        vecs.push_back(v("ar20_c1",   s_ar(8'h20),             1'b1, 32'h11111111, 1'b0, 1'b0, 32'hFFFF5678));
        vecs.push_back(v("ar20_c2",   s_ar(8'h20),             1'b0, 32'h11111111, 1'b1, 1'b0, 32'hFFFF5678));
        // Address wrap 0xFF -> 0x00
        vecs.push_back(v("ja_ff",     s_ja(1'b0, 8'hFF, 1'b0), 1'b0, 32'h11111111, 1'b1, 1'b0, 32'hFFFF5678));
        vecs.push_back(v("jb_at_ff",  s_jb(32'hA5A5A5A5),      1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 32'hFFFF5678));
        vecs.push_back(v("jb_at_00",  s_jb(32'h5A5A5A5A),      1'b0, 32'h5A5A5A5A, 1'b1, 1'b0, 32'hFFFF5678));
        vecs.push_back(v("ar00_c0",   s_ar(8'h00),             1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 32'hFFFF5678));
        vecs.push_back(v("ar00_c1",   s_ar(8'h00),             1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h5A5A5A5A));
        vecs.push_back(v("ar00_c2",   s_ar(8'h00),             1'b0, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h5A5A5A5A));
        vecs.push_back(v("arff_c0",   s_ar(8'hFF),             1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h5A5A5A5A));
        vecs.push_back(v("arff_c1",   s_ar(8'hFF),             1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 32'hA5A5A5A5));
        vecs.push_back(v("arff_c2",   s_ar(8'hFF),             1'b0, 32'h5A5A5A5A, 1'b1, 1'b0, 32'hA5A5A5A5));
        // JTAG beats Avalon in the same IDLE cycle
        vecs.push_back(v("jb_ar_col", s_or(s_jb(32'h77777777), s_ar(8'h01)), 1'b1, 32'h77777777, 1'b1, 1'b0, 32'hA5A5A5A5));
        vecs.push_back(v("ar01_c0",   s_ar(8'h01),             1'b1, 32'h77777777, 1'b0, 1'b0, 32'hA5A5A5A5));
        vecs.push_back(v("ar01_c1",   s_ar(8'h01),             1'b1, 32'h77777777, 1'b0, 1'b0, 32'h77777777));
        vecs.push_back(v("ar01_c2",   s_ar(8'h01),             1'b0, 32'h77777777, 1'b1, 1'b0, 32'h77777777));
        // Strobe while busy sets sticky error; Avalon write there is stalled and dropped
        vecs.push_back(v("ja_10_rd2", s_ja(1'b1, 8'h10, 1'b0), 1'b0, 32'h77777777, 1'b0, 1'b0, 32'h77777777));
        vecs.push_back(v("na_2",      s_na(),                  1'b0, 32'h77777777, 1'b0, 1'b0, 32'h77777777));
        vecs.push_back(v("jb_in_jrd", s_or(s_jb(32'hBAD0BAD0), s_aw(8'h10, 32'h0, 4'hF)), 1'b1, 32'h77777777, 1'b0, 1'b1, 32'h77777777));
        vecs.push_back(v("jcap_2",    s_idle(),                1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 32'h77777777));
        vecs.push_back(v("ja_errclr", s_ja(1'b0, 8'h50, 1'b1), 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h77777777));
        vecs.push_back(v("ar10_c0",   s_ar(8'h10),             1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h77777777));
        vecs.push_back(v("ar10_c1",   s_ar(8'h10),             1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(v("ar10_c2",   s_ar(8'h10),             1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF));
        // no_action with nothing pending does nothing
        vecs.push_back(v("na_nopend", s_na(),                  1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF));
        vecs.push_back(v("idle_after",s_idle(),                1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF));

        // Reset state
        reset_n = 1'b0;
        drive(s_idle());
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wait", 32'(avalon_waitrequest), 32'h0);
        chk_regs("rst", 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run(vecs[i]);

        // Reset during JCAP aborts the read; Avalon write under reset must not land
        run(v("r_ja",  s_ja(1'b1, 8'h10, 1'b0), 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF));
        run(v("r_na",  s_na(),                  1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF));
        run(v("r_jrd", s_idle(),                1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF));
        @(negedge clk);
        reset_n = 1'b0;
        drive(s_aw(8'h10, 32'h0, 4'hF));
        #1;
        chk_regs("rst_jcap_async", 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk_regs("rst_jcap_next", 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        drive(s_idle());
        reset_n = 1'b1;
        run(v("post_rst_ar_c0", s_ar(8'h10), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0));
        run(v("post_rst_ar_c1", s_ar(8'h10), 1'b1, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF));
        run(v("post_rst_ar_c2", s_ar(8'h10), 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF));

        @(negedge clk);
        drive(s_idle());
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
